// File: rtl/gpr_wb.sv
// gpr_wb: writeback stage driving both GPR write ports from two issue lanes plus a
// merged long-latency result path; `GPR_WB_STARVE_EN adds the starvation stall.
module gpr_wb #(
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        l0_valid,
    input  logic [4:0]  l0_rd,
    input  logic [31:0] l0_data,
    input  logic        l1_valid,
    input  logic [4:0]  l1_rd,
    input  logic [31:0] l1_data,
    input  logic        late_valid,
    input  logic [4:0]  late_rd,
    input  logic [31:0] late_data,
    output logic        late_ready,
    input  logic        alloc_valid,
    input  logic [4:0]  alloc_rd,
    output logic [31:0] busy,
    output logic        stall,
    output logic        we0,
    output logic        we1,
    output logic [4:0]  waddr0,
    output logic [4:0]  waddr1,
    output logic [31:0] wdata0,
    output logic [31:0] wdata1
);
    localparam int unsigned AW   = 5;
    localparam int unsigned DW   = 32;
    localparam int unsigned NREG = 32;

    if (STARVE_LIMIT < 1 || STARVE_LIMIT > 255) begin : g_bad_limit
        $error("gpr_wb: STARVE_LIMIT must be within 1..255");
    end

    logic            l0_idle, l1_idle, late_acc;
    logic            we0_q, we0_d, we1_q, we1_d;
    logic [AW-1:0]   waddr0_q, waddr0_d, waddr1_q, waddr1_d;
    logic [DW-1:0]   wdata0_q, wdata0_d, wdata1_q, wdata1_d;
    logic [NREG-1:0] busy_q, busy_d;

    // A late result may only use a port whose lane produces no write this cycle.
    always_comb begin
        l0_idle  = !l0_valid || (l0_rd == '0);
        l1_idle  = !l1_valid || (l1_rd == '0);
        late_acc = !rst && late_valid && (l0_idle || l1_idle);
    end

    assign late_ready = late_acc;

    // Next write-port contents and scoreboard update.
    always_comb begin
        we0_d    = !l0_idle;
        waddr0_d = l0_rd;
        wdata0_d = l0_data;
        we1_d    = !l1_idle;
        waddr1_d = l1_rd;
        wdata1_d = l1_data;
        busy_d   = busy_q;
        if (late_acc) begin
            if (l0_idle) begin
                we0_d    = (late_rd != '0);
                waddr0_d = late_rd;
                wdata0_d = late_data;
            end else begin
                we1_d    = (late_rd != '0);
                waddr1_d = late_rd;
                wdata1_d = late_data;
            end
            busy_d[late_rd] = 1'b0;
        end
        // Set after clear so a same-cycle alloc of the same register wins.
        if (alloc_valid) begin
            busy_d[alloc_rd] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            we0_q    <= 1'b0;
            we1_q    <= 1'b0;
            waddr0_q <= '0;
            waddr1_q <= '0;
            wdata0_q <= '0;
            wdata1_q <= '0;
            busy_q   <= '0;
        end else begin
            we0_q    <= we0_d;
            we1_q    <= we1_d;
            waddr0_q <= waddr0_d;
            waddr1_q <= waddr1_d;
            wdata0_q <= wdata0_d;
            wdata1_q <= wdata1_d;
            busy_q   <= busy_d;
        end
    end

    assign we0    = we0_q;
    assign we1    = we1_q;
    assign waddr0 = waddr0_q;
    assign waddr1 = waddr1_q;
    assign wdata0 = wdata0_q;
    assign wdata1 = wdata1_q;
    assign busy   = busy_q;

`ifdef GPR_WB_STARVE_EN
    localparam int unsigned CW = 8;
    localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

    logic [CW-1:0] starve_q, starve_d;
    logic          stall_q, stall_d;

    // Count consecutive rejected cycles; stall one cycle after the limit is reached.
    always_comb begin
        starve_d = starve_q;
        stall_d  = stall_q;
        if (!late_valid || late_acc) begin
            starve_d = '0;
        end else if (starve_q < LIMIT) begin
            starve_d = starve_q + CW'(1);
        end
        if (late_acc) begin
            stall_d = 1'b0;
        end else if (starve_q == LIMIT) begin
            stall_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            starve_q <= '0;
            stall_q  <= 1'b0;
        end else begin
            starve_q <= starve_d;
            stall_q  <= stall_d;
        end
    end

    assign stall = stall_q;
`else
    assign stall = 1'b0;
`endif

endmodule

// File: tb/tb_gpr_wb.sv
// Self-checking bench for gpr_wb: directed scenarios plus randomized traffic against a
// behavioural model of the writeback/late-merge/scoreboard rules.
module tb_gpr_wb;
    localparam int unsigned LIMIT = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        l0_valid, l1_valid, late_valid, alloc_valid;
    logic [4:0]  l0_rd, l1_rd, late_rd, alloc_rd;
    logic [31:0] l0_data, l1_data, late_data;
    logic        late_ready, stall, we0, we1;
    logic [31:0] busy, wdata0, wdata1;
    logic [4:0]  waddr0, waddr1;

    int n_cmp = 0;
    int n_bad = 0;

    // Model state: what the write ports, scoreboard and stall should show.
    logic        m_we0, m_we1;
    logic [4:0]  m_wa0, m_wa1;
    logic [31:0] m_wd0, m_wd1;
    logic [31:0] m_busy;
    logic        m_stall;
    int          m_wait;

    gpr_wb #(.STARVE_LIMIT(LIMIT)) dut (
        .clk(clk), .rst(rst),
        .l0_valid(l0_valid), .l0_rd(l0_rd), .l0_data(l0_data),
        .l1_valid(l1_valid), .l1_rd(l1_rd), .l1_data(l1_data),
        .late_valid(late_valid), .late_rd(late_rd), .late_data(late_data),
        .late_ready(late_ready),
        .alloc_valid(alloc_valid), .alloc_rd(alloc_rd),
        .busy(busy), .stall(stall),
        .we0(we0), .we1(we1), .waddr0(waddr0), .waddr1(waddr1),
        .wdata0(wdata0), .wdata1(wdata1)
    );

    always #5 clk = ~clk;

    function automatic logic [37:0] pw(input logic we, input logic [4:0] a, input logic [31:0] d);
        return we ? {1'b1, a, d} : 38'd0;
    endfunction

    function automatic logic m_ready();
        return late_valid && (!l0_valid || l0_rd == 5'd0 || !l1_valid || l1_rd == 5'd0);
    endfunction

    task automatic model_reset();
        m_we0 = 1'b0; m_we1 = 1'b0; m_wa0 = '0; m_wa1 = '0; m_wd0 = '0; m_wd1 = '0;
        m_busy = '0; m_stall = 1'b0; m_wait = 0;
    endtask

    task automatic idle_inputs();
        l0_valid = 1'b0; l0_rd = '0; l0_data = '0;
        l1_valid = 1'b0; l1_rd = '0; l1_data = '0;
        late_valid = 1'b0; late_rd = '0; late_data = '0;
        alloc_valid = 1'b0; alloc_rd = '0;
    endtask

    // Advance one clock and apply the same cycle's inputs to the model.
    task automatic tick();
        logic w0, w1, acc;
        w0  = l0_valid && l0_rd != 5'd0;
        w1  = l1_valid && l1_rd != 5'd0;
        acc = late_valid && (!w0 || !w1);
        @(posedge clk);
        #1;
        m_we0 = w0; m_wa0 = l0_rd; m_wd0 = l0_data;
        m_we1 = w1; m_wa1 = l1_rd; m_wd1 = l1_data;
        if (acc && !w0) begin
            m_we0 = late_rd != 5'd0; m_wa0 = late_rd; m_wd0 = late_data;
        end else if (acc) begin
            m_we1 = late_rd != 5'd0; m_wa1 = late_rd; m_wd1 = late_data;
        end
        if (acc) m_busy[late_rd] = 1'b0;
        if (alloc_valid && alloc_rd != 5'd0) m_busy[alloc_rd] = 1'b1;
`ifdef GPR_WB_STARVE_EN
        m_stall = !acc && (m_stall || m_wait >= int'(LIMIT));
`else
        m_stall = 1'b0;
`endif
        m_wait = (late_valid && !acc) ? m_wait + 1 : 0;
    endtask

    task automatic test_reset();
        idle_inputs();
        alloc_valid = 1'b1; alloc_rd = 5'd4;
        tick();
        alloc_valid = 1'b0;
        n_cmp++;
        if (busy !== 32'h0000_0010) begin
            n_bad++; $display("FAIL reset_prebusy got %h exp %h", busy, 32'h0000_0010);
        end
        late_valid = 1'b1; late_rd = 5'd4; late_data = 32'hCAFE_0004;
        l0_valid = 1'b1; l0_rd = 5'd2; l0_data = 32'h1;
        rst = 1'b1;
        #1;
        n_cmp++;
        if ({we0, we1, waddr0, waddr1, wdata0, wdata1, busy, stall, late_ready} !== '0) begin
            n_bad++;
            $display("FAIL reset_outputs got we=%b%b wa=%h/%h wd=%h/%h busy=%h stall=%b rdy=%b exp all 0",
                     we0, we1, waddr0, waddr1, wdata0, wdata1, busy, stall, late_ready);
        end
        @(posedge clk);
        #1;
        idle_inputs();
        rst = 1'b0;
        model_reset();
        tick();
        n_cmp++;
        if ({we0, we1, busy} !== 34'd0) begin
            n_bad++; $display("FAIL reset_release got we=%b%b busy=%h exp 0", we0, we1, busy);
        end
    endtask

    task automatic test_same_rd();
        idle_inputs();
        l0_valid = 1'b1; l0_rd = 5'd5; l0_data = 32'hAAAA_0001;
        l1_valid = 1'b1; l1_rd = 5'd5; l1_data = 32'hBBBB_0002;
        tick();
        n_cmp++;
        if (pw(we0, waddr0, wdata0) !== {1'b1, 5'd5, 32'hAAAA_0001}) begin
            n_bad++; $display("FAIL same_rd_p0 got %h exp %h", pw(we0, waddr0, wdata0), {1'b1, 5'd5, 32'hAAAA_0001});
        end
        n_cmp++;
        if (pw(we1, waddr1, wdata1) !== {1'b1, 5'd5, 32'hBBBB_0002}) begin
            n_bad++; $display("FAIL same_rd_p1 got %h exp %h", pw(we1, waddr1, wdata1), {1'b1, 5'd5, 32'hBBBB_0002});
        end
        idle_inputs();
        tick();
    endtask

    task automatic test_late_merge();
        idle_inputs();
        alloc_valid = 1'b1; alloc_rd = 5'd7;
        tick();
        alloc_valid = 1'b0;
        for (int c = 1; c <= 3; c++) begin
            n_cmp++;
            if (busy[7] !== 1'b1) begin
                n_bad++; $display("FAIL merge_busy_c%0d got %b exp 1", c, busy[7]);
            end
            if (c < 3) tick();
        end
        late_valid = 1'b1; late_rd = 5'd7; late_data = 32'h1234_5678;
        l0_valid = 1'b1; l0_rd = 5'd3; l0_data = 32'h0303_0303;
        l1_valid = 1'b1; l1_rd = 5'd0; l1_data = 32'h0;
        #1;
        n_cmp++;
        if (late_ready !== 1'b1) begin
            n_bad++; $display("FAIL merge_ready got %b exp 1", late_ready);
        end
        tick();
        idle_inputs();
        n_cmp++;
        if (pw(we1, waddr1, wdata1) !== {1'b1, 5'd7, 32'h1234_5678}) begin
            n_bad++; $display("FAIL merge_p1 got %h exp %h", pw(we1, waddr1, wdata1), {1'b1, 5'd7, 32'h1234_5678});
        end
        n_cmp++;
        if (pw(we0, waddr0, wdata0) !== {1'b1, 5'd3, 32'h0303_0303}) begin
            n_bad++; $display("FAIL merge_p0 got %h exp %h", pw(we0, waddr0, wdata0), {1'b1, 5'd3, 32'h0303_0303});
        end
        n_cmp++;
        if (busy[7] !== 1'b0) begin
            n_bad++; $display("FAIL merge_busy_clr got %b exp 0", busy[7]);
        end
    endtask

    task automatic test_starve();
        idle_inputs();
        l0_valid = 1'b1; l0_rd = 5'd10; l0_data = 32'h0A0A_0A0A;
        l1_valid = 1'b1; l1_rd = 5'd11; l1_data = 32'h0B0B_0B0B;
        late_valid = 1'b1; late_rd = 5'd12; late_data = 32'hDEAD_BEEF;
`ifdef GPR_WB_STARVE_EN
        for (int i = 0; i < 5; i++) begin
            #1;
            n_cmp++;
            if (late_ready !== 1'b0) begin
                n_bad++; $display("FAIL starve_ready_%0d got %b exp 0", i, late_ready);
            end
            tick();
            n_cmp++;
            if (stall !== (i == 4)) begin
                n_bad++; $display("FAIL starve_stall_%0d got %b exp %b", i, stall, i == 4);
            end
        end
`else
        for (int i = 0; i < 20; i++) begin
            #1;
            tick();
            n_cmp++;
            if ({stall, late_ready} !== 2'b00) begin
                n_bad++; $display("FAIL nostarve_%0d got stall=%b rdy=%b exp 0 0", i, stall, late_ready);
            end
        end
`endif
        l0_valid = 1'b0; l1_valid = 1'b0;
        #1;
        n_cmp++;
        if (late_ready !== 1'b1) begin
            n_bad++; $display("FAIL starve_accept got %b exp 1", late_ready);
        end
        tick();
        idle_inputs();
        n_cmp++;
        if ({pw(we0, waddr0, wdata0), stall} !== {1'b1, 5'd12, 32'hDEAD_BEEF, 1'b0}) begin
            n_bad++; $display("FAIL starve_drain got p0=%h stall=%b exp %h 0",
                              pw(we0, waddr0, wdata0), stall, {1'b1, 5'd12, 32'hDEAD_BEEF});
        end
    endtask

    task automatic test_alloc_collision();
        idle_inputs();
        alloc_valid = 1'b1; alloc_rd = 5'd9;
        late_valid = 1'b1; late_rd = 5'd9; late_data = 32'h0000_0055;
        #1;
        tick();
        n_cmp++;
        if ({busy[9], pw(we0, waddr0, wdata0)} !== {1'b1, 1'b1, 5'd9, 32'h55}) begin
            n_bad++; $display("FAIL collide_set got busy9=%b p0=%h exp 1 %h", busy[9], pw(we0, waddr0, wdata0), {1'b1, 5'd9, 32'h55});
        end
        idle_inputs();
        alloc_valid = 1'b1; alloc_rd = 5'd0;
        tick();
        n_cmp++;
        if ({busy[0], busy[9]} !== 2'b01) begin
            n_bad++; $display("FAIL alloc_r0 got busy0=%b busy9=%b exp 0 1", busy[0], busy[9]);
        end
        idle_inputs();
        late_valid = 1'b1; late_rd = 5'd9; late_data = 32'h99;
        tick();
        idle_inputs();
        n_cmp++;
        if (busy[9] !== 1'b0) begin
            n_bad++; $display("FAIL collide_clr got %b exp 0", busy[9]);
        end
    endtask

    task automatic test_rd0();
        idle_inputs();
        l0_valid = 1'b1; l0_rd = 5'd0; l0_data = 32'hFFFF_FFFF;
        late_valid = 1'b1; late_rd = 5'd0; late_data = 32'h7777_7777;
        #1;
        n_cmp++;
        if (late_ready !== 1'b1) begin
            n_bad++; $display("FAIL rd0_ready got %b exp 1", late_ready);
        end
        tick();
        idle_inputs();
        n_cmp++;
        if ({we0, we1} !== 2'b00) begin
            n_bad++; $display("FAIL rd0_we got %b%b exp 00", we0, we1);
        end
    endtask

    task automatic test_random();
        logic hold;
        hold = 1'b0;
        idle_inputs();
        for (int c = 0; c < 400; c++) begin
            l0_valid = 1'($urandom_range(0, 1)) && !m_stall;
            l0_rd = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
            l0_data = $urandom;
            l1_valid = 1'($urandom_range(0, 1)) && !m_stall;
            l1_rd = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
            l1_data = $urandom;
            alloc_valid = ($urandom_range(0, 2) == 0);
            alloc_rd = 5'($urandom_range(0, 31));
            if (!hold) begin
                late_valid = 1'($urandom_range(0, 1));
                late_rd = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
                late_data = $urandom;
            end
            #1;
            n_cmp++;
            if (late_ready !== m_ready()) begin
                n_bad++; $display("FAIL rnd_ready c%0d got %b exp %b", c, late_ready, m_ready());
            end
            hold = late_valid && !m_ready();
            tick();
            n_cmp++;
            if (pw(we0, waddr0, wdata0) !== pw(m_we0, m_wa0, m_wd0)) begin
                n_bad++; $display("FAIL rnd_p0 c%0d got %h exp %h", c, pw(we0, waddr0, wdata0), pw(m_we0, m_wa0, m_wd0));
            end
            n_cmp++;
            if (pw(we1, waddr1, wdata1) !== pw(m_we1, m_wa1, m_wd1)) begin
                n_bad++; $display("FAIL rnd_p1 c%0d got %h exp %h", c, pw(we1, waddr1, wdata1), pw(m_we1, m_wa1, m_wd1));
            end
            n_cmp++;
            if ({busy, stall} !== {m_busy, m_stall}) begin
                n_bad++; $display("FAIL rnd_busy c%0d got %h/%b exp %h/%b", c, busy, stall, m_busy, m_stall);
            end
        end
        idle_inputs();
    endtask

    initial begin
        rst = 1'b1;
        idle_inputs();
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        test_reset();
        test_same_rd();
        test_late_merge();
        test_starve();
        test_alloc_collision();
        test_rd0();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
